// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer for the MIPS-subset datapath: fetch/decode/execute/
// memory/writeback stepping with a memory-ready wait counter and timeout abort.
module mc_ctrl_fsm #(
  parameter int WAIT_LIMIT = 0,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] alu_imm_sel,
  output logic [1:0] pc_source,
  output logic       ext_op,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_RTWB   = 4'd7,
    S_BRANCH  = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  typedef struct packed {
    logic       fetch_rd;
    logic       jmp_pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] alu_imm_sel;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  // Control word for a state; opcode only matters for states entered from DECODE.
  function automatic ctl_t decode_ctl(input state_t st, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH:   begin c.fetch_rd = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_RTEXEC:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RTWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.branch_ne     = (op == OP_BNE);
      end
      S_JUMP:    begin c.jmp_pc_write = 1'b1; c.pc_source = 2'b10; end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b11;
        case (op)
          OP_ANDI: c.alu_imm_sel = 2'b01;
          OP_ORI:  c.alu_imm_sel = 2'b10;
          OP_SLTI: c.alu_imm_sel = 2'b11;
          default: c.alu_imm_sel = 2'b00;
        endcase
      end
      S_IWB:     c.reg_write = 1'b1;
      S_ILLEGAL: c.illegal_op = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic ext_sign(input logic [5:0] op);
    return !((op == OP_ANDI) || (op == OP_ORI));
  endfunction

  state_t           r_state;
  logic             r_started;
  logic [CNT_W-1:0] r_cnt;
  ctl_t             r_ctl;
  logic             r_ext_op;
  logic             r_timeout;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_abort;
  logic             w_limit_hit;
  logic             w_waiting;

  // Next-state, abort and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    w_limit_hit = (WAIT_LIMIT != 0) && (r_cnt == LIMIT_M1);
    w_waiting   = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                  && !mem_ready;
    if (!r_started) begin
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready)        w_state_nxt = S_DECODE;
          else if (w_limit_hit) w_abort = 1'b1;
          else                  w_state_nxt = S_FETCH;
        end
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:                          w_state_nxt = S_RTEXEC;
            OP_LW, OP_SW:                      w_state_nxt = S_MEMADR;
            OP_BEQ, OP_BNE:                    w_state_nxt = S_BRANCH;
            OP_J:                              w_state_nxt = S_JUMP;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_state_nxt = S_IEXEC;
            default:                           w_state_nxt = S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_SW) w_state_nxt = S_MEMWR;
          else                 w_state_nxt = S_MEMRD;
        end
        S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            w_state_nxt = (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
          end else if (w_limit_hit) begin
            w_abort     = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_RTEXEC: w_state_nxt = S_RTWB;
        S_IEXEC:  w_state_nxt = S_IWB;
        default:  w_state_nxt = S_FETCH;
      endcase
    end
    // An abort from FETCH stays in FETCH, so it must clear the count explicitly.
    if (!r_started || w_abort || (w_state_nxt != r_state)) begin
      w_cnt_nxt = '0;
    end else if (w_waiting) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // State, counter and registered control word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_started <= 1'b0;
      r_cnt     <= '0;
      r_ctl     <= '0;
      r_ext_op  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ctl     <= decode_ctl(w_state_nxt, opcode);
      r_timeout <= w_abort;
      if (w_state_nxt == S_FETCH)  r_ext_op <= 1'b0;
      else if (r_state == S_DECODE) r_ext_op <= ext_sign(opcode);
      else                          r_ext_op <= r_ext_op;
    end
  end

  // IR/PC loads in FETCH fire only in the cycle memory completes.
  assign ir_write      = r_ctl.fetch_rd & mem_ready;
  assign pc_write      = (r_ctl.fetch_rd & mem_ready) | r_ctl.jmp_pc_write;
  assign pc_write_cond = r_ctl.pc_write_cond;
  assign branch_ne     = r_ctl.branch_ne;
  assign i_or_d        = r_ctl.i_or_d;
  assign mem_read      = r_ctl.mem_read;
  assign mem_write     = r_ctl.mem_write;
  assign mem_to_reg    = r_ctl.mem_to_reg;
  assign reg_dst       = r_ctl.reg_dst;
  assign reg_write     = r_ctl.reg_write;
  assign alu_src_a     = r_ctl.alu_src_a;
  assign alu_src_b     = r_ctl.alu_src_b;
  assign alu_op        = r_ctl.alu_op;
  assign alu_imm_sel   = r_ctl.alu_imm_sel;
  assign pc_source     = r_ctl.pc_source;
  assign ext_op        = (r_state == S_DECODE) ? ext_sign(opcode) : r_ext_op;
  assign illegal_op    = r_ctl.illegal_op;
  assign mem_timeout   = r_timeout;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected control vectors for each scenario.
module tb_mc_ctrl_fsm;
  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, alu_imm_sel, pc_source;
  logic       ext_op, illegal_op, mem_timeout;
  logic [21:0] obs;
  int n_cmp;
  int n_bad;

  localparam logic [21:0] M_PCW   = 22'b1 << 21;
  localparam logic [21:0] M_PCWC  = 22'b1 << 20;
  localparam logic [21:0] M_BNE   = 22'b1 << 19;
  localparam logic [21:0] M_IORD  = 22'b1 << 18;
  localparam logic [21:0] M_MRD   = 22'b1 << 17;
  localparam logic [21:0] M_MWR   = 22'b1 << 16;
  localparam logic [21:0] M_IRW   = 22'b1 << 15;
  localparam logic [21:0] M_M2R   = 22'b1 << 14;
  localparam logic [21:0] M_RDST  = 22'b1 << 13;
  localparam logic [21:0] M_RW    = 22'b1 << 12;
  localparam logic [21:0] M_SRCA  = 22'b1 << 11;
  localparam logic [21:0] M_B4    = 22'b01 << 9;
  localparam logic [21:0] M_BIMM  = 22'b10 << 9;
  localparam logic [21:0] M_BSH   = 22'b11 << 9;
  localparam logic [21:0] M_SUB   = 22'b01 << 7;
  localparam logic [21:0] M_FN    = 22'b10 << 7;
  localparam logic [21:0] M_IMMOP = 22'b11 << 7;
  localparam logic [21:0] M_SELOR = 22'b10 << 5;
  localparam logic [21:0] M_PCOUT = 22'b01 << 3;
  localparam logic [21:0] M_EXT   = 22'b1 << 2;
  localparam logic [21:0] M_ILL   = 22'b1 << 1;
  localparam logic [21:0] M_TMO   = 22'b1;
  localparam logic [21:0] E_FRDY  = M_MRD | M_B4 | M_IRW | M_PCW;
  localparam logic [21:0] E_FWAIT = M_MRD | M_B4;

  mc_ctrl_fsm #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_imm_sel(alu_imm_sel), .pc_source(pc_source), .ext_op(ext_op),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  assign obs = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, alu_imm_sel,
                pc_source, ext_op, illegal_op, mem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 22'h0) begin $display("FAIL reset_hold got %h want %h", obs, 22'h0); n_bad++; end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 22'h0) begin $display("FAIL reset_release got %h want %h", obs, 22'h0); n_bad++; end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    logic [21:0] e [0:4];
    e = '{E_FRDY, M_BSH | M_EXT, M_SRCA | M_BIMM | M_EXT, M_MRD | M_IORD | M_EXT, M_RW | M_M2R | M_EXT};
    opcode = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; #1;
      n_cmp++;
      if (obs !== e[i]) begin $display("FAIL lw cyc%0d got %h want %h", i, obs, e[i]); n_bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ori();
    logic [21:0] e [0:3];
    e = '{E_FRDY, M_BSH, M_SRCA | M_BIMM | M_IMMOP | M_SELOR, M_RW};
    opcode = 6'b001101;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      n_cmp++;
      if (obs !== e[i]) begin $display("FAIL ori cyc%0d got %h want %h", i, obs, e[i]); n_bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bne();
    logic [21:0] e [0:2];
    e = '{E_FRDY, M_BSH | M_EXT, M_SRCA | M_SUB | M_PCWC | M_BNE | M_PCOUT | M_EXT};
    opcode = 6'b000101;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1;
      n_cmp++;
      if (obs !== e[i]) begin $display("FAIL bne cyc%0d got %h want %h", i, obs, e[i]); n_bad++; end
      @(posedge clk); #1;
    end
  endtask

  // Three stalled fetch cycles then completion on the 4th (the wait-limit boundary).
  task automatic test_fetch_stall();
    logic [21:0] e [0:6];
    logic        mr [0:6];
    e  = '{E_FWAIT, E_FWAIT, E_FWAIT, E_FRDY, M_BSH | M_EXT, M_SRCA | M_FN | M_EXT,
           M_RW | M_RDST | M_EXT};
    mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    opcode = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      n_cmp++;
      if (obs !== e[i]) begin $display("FAIL fetch_stall cyc%0d got %h want %h", i, obs, e[i]); n_bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_timeout();
    logic [21:0] e [0:8];
    logic        mr [0:8];
    e  = '{E_FRDY, M_BSH | M_EXT, M_SRCA | M_BIMM | M_EXT,
           M_MWR | M_IORD | M_EXT, M_MWR | M_IORD | M_EXT, M_MWR | M_IORD | M_EXT,
           M_MWR | M_IORD | M_EXT, E_FWAIT | M_TMO, E_FWAIT};
    mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    opcode = 6'b101011;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr[i]; #1;
      n_cmp++;
      if (obs !== e[i]) begin $display("FAIL sw_timeout cyc%0d got %h want %h", i, obs, e[i]); n_bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [21:0] e [0:3];
    e = '{E_FRDY, M_BSH | M_EXT, M_ILL | M_EXT, E_FWAIT};
    opcode = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3) ? 1'b0 : 1'b1; #1;
      n_cmp++;
      if (obs !== e[i]) begin $display("FAIL illegal cyc%0d got %h want %h", i, obs, e[i]); n_bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] e [0:6];
    e = '{E_FRDY, M_BSH | M_EXT, M_SRCA | M_FN | M_EXT, E_FRDY, M_BSH | M_EXT,
          M_SRCA | M_FN | M_EXT, M_RW | M_RDST | M_EXT};
    opcode = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1;
      n_cmp++;
      if (obs !== e[i]) begin $display("FAIL rst_mid cyc%0d got %h want %h", i, obs, e[i]); n_bad++; end
      if (i < 2) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if (obs !== 22'h0) begin $display("FAIL rst_mid_async got %h want %h", obs, 22'h0); n_bad++; end
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 22'h0) begin $display("FAIL rst_mid_held got %h want %h", obs, 22'h0); n_bad++; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 3; i < 7; i++) begin
      mem_ready = 1'b1; #1;
      n_cmp++;
      if (obs !== e[i]) begin $display("FAIL rst_mid cyc%0d got %h want %h", i, obs, e[i]); n_bad++; end
      @(posedge clk); #1;
    end
    #1;
    n_cmp++;
    if (obs !== E_FRDY) begin $display("FAIL rst_mid_end got %h want %h", obs, E_FRDY); n_bad++; end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'b000000;
    test_reset();
    test_lw();
    test_ori();
    test_bne();
    test_fetch_stall();
    test_sw_timeout();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control sequencer for the MIPS-subset CPU datapath.
- Decodes the opcode latched in IR and steps the shared ALU, the memory port, the register file and the immediate extender through fetch/decode/execute/memory/writeback.
- Drives ext_op for the immediate extender: sign-extend vs zero-extend of IMM[15:0] to 32 bits.
- Stalls on a memory ready handshake; flags illegal opcodes and memory timeouts.

Parameters:
- WAIT_LIMIT, 0, max cycles to wait for mem_ready in any memory state; 0 = wait forever.
- CNT_W, 8, width of the wait counter; must satisfy WAIT_LIMIT < 2^CNT_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- mem_ready  input  1  memory completes the current read or write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load qualified by the ALU zero flag.
- branch_ne  output  1  1 = take branch on !zero (bne); 0 = take on zero (beq).
- i_or_d  output  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  load IR from memory data.
- mem_to_reg  output  1  writeback source: 1 = MDR, 0 = ALUOut.
- reg_dst  output  1  destination register: 1 = rd, 0 = rt.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A operand: 0 = PC, 1 = regA.
- alu_src_b  output  2  ALU B operand: 00 = regB, 01 = constant 4, 10 = extended imm, 11 = extended imm<<2.
- alu_op  output  2  00 = add, 01 = sub, 10 = use funct field, 11 = use alu_imm_sel.
- alu_imm_sel  output  2  immediate ALU operation: 00 = add, 01 = and, 10 = or, 11 = slt.
- pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ext_op  output  1  1 = sign-extend, 0 = zero-extend.
- illegal_op  output  1  one-cycle pulse on an undefined opcode.
- mem_timeout  output  1  one-cycle pulse when a memory wait is aborted.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BRANCH, JUMP, IEXEC, IWB, ILLEGAL.
- Reset (async, rst_n=0): state = FETCH, wait counter = 0, all outputs 0. On release, the first edge begins FETCH.
- All outputs are decoded from the current state; mem_ready gating is the only input dependence. Outputs not listed for a state are 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - Leave to DECODE only when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - ext_op=1, except 0 for andi(001100)/ori(001101).
  - Next state by opcode:
    - 000000 -> RTEXEC
    - 100011 or 101011 -> MEMADR
    - 000100 or 000101 -> BRANCH
    - 000010 -> JUMP
    - 001000, 001010, 001100, 001101 -> IEXEC
    - any other -> ILLEGAL
- ext_op is held from DECODE through the end of the instruction. It is registered at the DECODE edge and cleared on return to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1; advance to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: mem_write=1, i_or_d=1; advance to FETCH on mem_ready.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - branch_ne = (opcode==000101).
  - -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- IEXEC:
  - alu_src_a=1, alu_src_b=10, alu_op=11.
  - alu_imm_sel: addi=00, andi=01, ori=10, slti=11.
  - -> IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- ILLEGAL: illegal_op=1 for exactly one cycle; no register or memory write -> FETCH. The PC has already advanced by 4, so the instruction is skipped.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Increments each cycle the state waits with mem_ready=0; clears on every state change.
  - If WAIT_LIMIT≠0 and the count reaches WAIT_LIMIT with mem_ready still 0: pulse mem_timeout, go to FETCH, no ir_write/pc_write/reg_write.
  - mem_ready=1 in the same cycle as limit reached: the completion wins, no timeout.
- Reset asserted mid-instruction: immediate return to FETCH with all outputs 0. No partial write survives the reset cycle.
- mem_ready is ignored in states that do not access memory.

Test Plan:
- Reset, then lw (opcode 100011) with mem_ready=1 every cycle -> FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH (5 cycles); ext_op=1 from DECODE; reg_write=1, mem_to_reg=1 only in MEMWB.
- ori (001101) -> IEXEC outputs alu_op=11, alu_imm_sel=10, ext_op=0; IWB reg_write=1, reg_dst=0; 4 cycles total.
- bne (000101) -> BRANCH with pc_write_cond=1, branch_ne=1, alu_op=01, pc_source=01; 3 cycles; no reg_write at any point.
- FETCH with mem_ready held 0 for 3 cycles, then 1 -> mem_read stays 1 throughout; ir_write=pc_write=1 only on the 4th cycle.
- WAIT_LIMIT=4, mem_ready stuck 0 in MEMWR -> mem_timeout pulses once after 4 wait cycles; next state FETCH; mem_write drops.
- Opcode 111111 -> ILLEGAL: illegal_op pulses 1 cycle, then FETCH. Separately, rst_n=0 mid-RTEXEC -> all outputs 0 immediately; FETCH after release.
